// File: rtl/directed_bus_stub.sv
// Bus-side stimulus stub for MR1 benches: plays a fixed program, answers reads
// with a constant, applies ready patterns and counts RVFI retirements.

module directed_bus_stub_dly #(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        out_valid,
   output logic [31:0] out_data
);
   logic [LAT-1:0]       vld_pipe;
   logic [LAT-1:0][31:0] dat_pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_valid;
         dat_pipe[0] <= in_valid ? in_data : 32'd0;
         for (int k = 1; k < LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            dat_pipe[k] <= dat_pipe[k-1];
         end
      end
   end

   assign out_valid = vld_pipe[LAT-1];
   assign out_data  = dat_pipe[LAT-1];
endmodule

module directed_bus_stub #(
   parameter int          PROG_DEPTH       = 8,
   parameter int          RSP_LATENCY      = 1,
   parameter logic [7:0]  INSTR_READY_MASK = 8'hFF,
   parameter logic [7:0]  DATA_READY_MASK  = 8'hFF,
   parameter logic [31:0] FILL_INSN        = 32'h0000_0013,
   parameter logic [31:0] DATA_RSP_VALUE   = 32'h1,
   parameter int          TRIG_INSNS       = 4,
   parameter int          TRIG_CYCLES      = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [32*PROG_DEPTH-1:0] prog_data,
   input  logic                     instr_req_valid,
   output logic                     instr_req_ready,
   input  logic [31:0]              instr_req_addr,
   output logic                     instr_rsp_valid,
   output logic [31:0]              instr_rsp_data,
   input  logic                     data_req_valid,
   output logic                     data_req_ready,
   input  logic                     data_req_wr,
   input  logic [1:0]               data_req_size,
   input  logic [31:0]              data_req_addr,
   input  logic [31:0]              data_req_data,
   output logic                     data_rsp_valid,
   output logic [31:0]              data_rsp_data,
   input  logic                     rvfi_valid,
   input  logic [31:0]              rvfi_insn,
   input  logic [3:0]               rvfi_mem_rmask,
   input  logic [3:0]               rvfi_mem_wmask,
   output logic                     trigger,
   output logic                     done,
   output logic [31:0]              count_instr_reqs,
   output logic [31:0]              count_longinsn,
   output logic [31:0]              count_dmemrd,
   output logic [31:0]              count_dmemwr,
   output logic [31:0]              count_cycles
);
   localparam int IW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   logic [PROG_DEPTH-1:0][31:0] prog_words;
   logic [2:0]  phase;
   logic [31:0] instr_reqs_q, longinsn_q, dmemrd_q, dmemwr_q, cycles_q;
   logic        done_q;
   logic        instr_acc, data_rd_acc, trig_cond;
   logic [31:0] instr_word;
   logic        irsp_vld, drsp_vld;
   logic [31:0] irsp_dat, drsp_dat;
   logic        unused_ok;

   assign prog_words = prog_data;
   assign unused_ok  = ^{instr_req_addr, data_req_size, data_req_addr, data_req_data, rvfi_insn[31:2]};

   assign instr_req_ready = INSTR_READY_MASK[phase] & ~reset;
   assign data_req_ready  = DATA_READY_MASK[phase] & ~reset;
   assign instr_acc       = instr_req_valid & instr_req_ready;
   assign data_rd_acc     = data_req_valid & data_req_ready & ~data_req_wr;

   // Word chosen by acceptance order (pre-increment count); address is ignored.
   assign instr_word = (instr_reqs_q < 32'(PROG_DEPTH)) ? prog_words[instr_reqs_q[IW-1:0]]
                                                         : FILL_INSN;

   assign trig_cond = (longinsn_q == 32'(TRIG_INSNS)) || (cycles_q == 32'(TRIG_CYCLES));
   assign trigger   = ~reset & trig_cond & ~done_q;
   assign done      = ~reset & done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase        <= 3'd0;
         instr_reqs_q <= '0;
         longinsn_q   <= '0;
         dmemrd_q     <= '0;
         dmemwr_q     <= '0;
         cycles_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         phase    <= phase + 3'd1;
         cycles_q <= sat_inc(cycles_q);
         if (instr_acc) instr_reqs_q <= sat_inc(instr_reqs_q);
         if (rvfi_valid) begin
            if (rvfi_insn[1:0] == 2'b11) longinsn_q <= sat_inc(longinsn_q);
            if (|rvfi_mem_rmask)         dmemrd_q   <= sat_inc(dmemrd_q);
            if (|rvfi_mem_wmask)         dmemwr_q   <= sat_inc(dmemwr_q);
         end
         if (trigger) done_q <= 1'b1;
      end
   end

   directed_bus_stub_dly #(.LAT(RSP_LATENCY)) u_irsp (
      .clk(clk), .reset(reset), .in_valid(instr_acc), .in_data(instr_word),
      .out_valid(irsp_vld), .out_data(irsp_dat)
   );

   directed_bus_stub_dly #(.LAT(RSP_LATENCY)) u_drsp (
      .clk(clk), .reset(reset), .in_valid(data_rd_acc), .in_data(DATA_RSP_VALUE),
      .out_valid(drsp_vld), .out_data(drsp_dat)
   );

   // Registered state may be stale during the reset cycle, so outputs are forced low.
   assign instr_rsp_valid  = irsp_vld & ~reset;
   assign instr_rsp_data   = instr_rsp_valid ? irsp_dat : 32'd0;
   assign data_rsp_valid   = drsp_vld & ~reset;
   assign data_rsp_data    = data_rsp_valid ? drsp_dat : 32'd0;

   assign count_instr_reqs = reset ? 32'd0 : instr_reqs_q;
   assign count_longinsn   = reset ? 32'd0 : longinsn_q;
   assign count_dmemrd     = reset ? 32'd0 : dmemrd_q;
   assign count_dmemwr     = reset ? 32'd0 : dmemwr_q;
   assign count_cycles     = reset ? 32'd0 : cycles_q;
endmodule
